ysyx_24100027_mdu_seq: RTL
==========================

Name: ysyx_24100027_mdu_seq

Overview:
Multi-cycle RV32M multiply/divide sequencer beside the single-cycle ALU in the EXU. It accepts one M-extension op over a valid/ready handshake and runs 32 iterations through a shared shift-add/shift-subtract datapath. It then applies sign fix-up and holds the result until the consumer accepts it. The EXU stalls on in_ready/out_valid; flush cancels any op in flight.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  op request
in_ready  out  1  sequencer can accept (state==IDLE)
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  in  XLEN  rs1 value / dividend
src2  in  XLEN  rs2 value / divisor
flush  in  1  cancel current op (redirect/trap)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  final value
busy  out  1  state!=IDLE

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, operand regs=0.
- Accept on rising edge where in_valid&&in_ready&&!flush. op/src1/src2 latched then; later input changes have no effect.
- FSM states: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: in_ready=1.
  - PREP (1 cycle): record signs; take magnitudes (signed operands per op: MUL/MULH/DIV/REM both, MULHSU src1 only, MULHU/DIVU/REMU none); clear 64-bit accumulator; counter=0; detect special cases.
  - CALC: exactly XLEN cycles, one iteration per cycle.
    - Multiply: if multiplier LSB is 1, add multiplicand into acc high half; shift right 1.
    - Divide: restoring; shift {rem,quot} left 1; trial-subtract divisor; keep if non-negative, set quotient bit.
    - Counter increments each cycle; leave CALC when counter==XLEN-1.
  - FIX (1 cycle): negate if required.
    - Product sign = s1^s2 (MULHSU: s1).
    - Quotient sign = s1^s2.
    - Remainder sign = s1.
    - Select low (MUL) or high (MULH*) word, quotient (DIV*) or remainder (REM*); register into result.
  - DONE: out_valid=1, result stable. On out_valid&&out_ready go to IDLE; in_ready rises the next cycle (no same-cycle re-accept).
- Latency: out_valid asserted 35 cycles after accept edge (PREP 1 + CALC 32 + FIX 1 + 1).
- Special cases (results fixed regardless of feature):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=src1.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV=0x80000000, REM=0.
- flush: in any state, next state=IDLE, out_valid=0, result unchanged, in_ready=1 next cycle. flush with in_valid in IDLE: no accept. flush during DONE with out_ready: treated as flush; consumer must ignore.
- reset mid-op behaves as flush plus result=0.
- Arithmetic: adder/subtractor XLEN+1 bits wide for divide trial (borrow = bit XLEN). Accumulator 2*XLEN. Counter wraps never (cleared in PREP).

Optional Feature:
YSYX_24100027_MDU_FAST_PATH_EN
- Defined: these ops go PREP -> DONE directly, skipping CALC/FIX, with out_valid 2 cycles after accept:
  - divide-by-zero;
  - signed overflow;
  - multiply with either source equal to 0 (result 0).
- Undefined: every op takes the full 35-cycle path; results are identical either way.

Decomposition:
- Package ysyx_24100027_mdu_pkg:
  - XLEN constant;
  - op funct3 localparams (MDU_MUL..MDU_REMU);
  - state encoding (IDLE, PREP, CALC, FIX, DONE);
  - helper for "op is divide" / "op selects high word".
- Sub-module ysyx_24100027_mdu_iter: combinational single-iteration step (shift-add or shift-subtract on the 64-bit acc plus operand, selected by is_div). The FSM, counter, sign fix-up and handshake stay in mdu_seq.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid first high exactly 35 cycles after accept.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9÷2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100÷7 -> 14; REMU -> 2.
- DIVU 5÷0 -> 0xFFFFFFFF; REM 5÷0 -> 5; DIV 0x80000000÷0xFFFFFFFF -> 0x80000000; REM -> 0. Latency 2 with the macro, 35 without.
- Backpressure: out_ready=0 for 10 cycles in DONE -> result/out_valid stable, in_ready=0; in_valid held high is not accepted. After handshake, in_ready=1 the next cycle.
- flush on 10th CALC cycle -> no out_valid; in_ready=1 next cycle. Then DIV 20÷3 -> 6, unaffected by the cancelled op. Reset asserted mid-CALC -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ysyx_24100027_mdu_pkg.sv
// ysyx_24100027_mdu_pkg
// Shared constants, the RV32M funct3 encodings, the sequencer state
// encoding and small op-decode helpers for the multiply/divide sequencer.
package ysyx_24100027_mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  // funct3 encodings of the M extension
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MULH, MULHSU, MULHU return the upper half of the product
  function automatic logic op_sel_high(input logic [2:0] op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

  function automatic logic op_src1_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_src2_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ysyx_24100027_mdu_iter.sv
// ysyx_24100027_mdu_iter
// One combinational iteration of the shared multiply/divide datapath.
//   is_div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i     : 64-bit accumulator. Multiply: {partial product, multiplier}.
//               Divide: {partial remainder, dividend/quotient}.
//   operand_i : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o     : accumulator after this iteration
module ysyx_24100027_mdu_iter
  import ysyx_24100027_mdu_pkg::*;
(
  input  logic                is_div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     operand_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   sub_rem;
  logic [XLEN:0]   sub_diff;
  logic [XLEN-1:0] shl_quot;

  always_comb begin
    acc_o    = '0;
    // multiply: conditional add into the high half, keeping the carry so the
    // right shift brings it back into bit 63
    add_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // divide: {rem,quot} shifted left by one; the shifted remainder needs
    // XLEN+1 bits and the trial subtraction's bit XLEN is the borrow
    sub_rem  = acc_i[2*XLEN-1:XLEN-1];
    shl_quot = {acc_i[XLEN-2:0], 1'b0};
    sub_diff = sub_rem - {1'b0, operand_i};
    if (is_div_i) begin
      if (!sub_diff[XLEN]) begin
        acc_o = {sub_diff[XLEN-1:0], shl_quot[XLEN-1:1], 1'b1};
      end else begin
        acc_o = {sub_rem[XLEN-1:0], shl_quot};
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ysyx_24100027_mdu_seq.sv
// ysyx_24100027_mdu_seq
// Multi-cycle RV32M multiply/divide sequencer. One op is accepted, its
// operand magnitudes are run through XLEN shift-add / shift-subtract
// iterations, the sign is fixed up and the result is held until taken.
//
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, op, src1, src2 : request channel
//   flush         : cancel any op in flight (next state IDLE)
//   out_valid/out_ready, result       : response channel
//   busy          : sequencer not idle
//   dbg_state_o   : current FSM state (mdu_state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and a request is refused while
// flush is high); out_valid is high only in DONE and result is stable for as
// long as out_valid is high. Neither ready depends combinationally on the
// matching valid.
//
// Optional build macro: YSYX_24100027_MDU_FAST_PATH_EN -- divide-by-zero,
// signed overflow and multiply-by-zero skip CALC/FIX and go PREP -> DONE.
module ysyx_24100027_mdu_seq
  import ysyx_24100027_mdu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [2:0]      dbg_state_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   result_q, result_d;

  // operand decode, valid whenever a_q/b_q/op_q hold a latched op
  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, sgn_ovf, mul_zero, special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] iter_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, calc_res;

  ysyx_24100027_mdu_iter u_iter (
    .is_div_i  (op_is_div(op_q)),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (iter_acc)
  );

  always_comb begin
    s1   = op_src1_signed(op_q) & a_q[XLEN-1];
    s2   = op_src2_signed(op_q) & b_q[XLEN-1];
    mag1 = s1 ? -a_q : a_q;
    mag2 = s2 ? -b_q : b_q;

    div_zero = op_is_div(op_q) && (b_q == '0);
    sgn_ovf  = ((op_q == MDU_DIV) || (op_q == MDU_REM)) &&
               (a_q == INT_MIN) && (b_q == '1);
    mul_zero = !op_is_div(op_q) && ((a_q == '0) || (b_q == '0));
    special  = div_zero || sgn_ovf || mul_zero;

    // fixed architectural results; multiply-by-zero is simply 0
    special_res = '0;
    if (div_zero) begin
      special_res = op_is_rem(op_q) ? a_q : '1;
    end else if (sgn_ovf) begin
      special_res = op_is_rem(op_q) ? '0 : INT_MIN;
    end

    // acc_q holds the unsigned 64-bit product or {rem, quot}
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_is_div(op_q)) begin
      calc_res = op_is_rem(op_q) ? rem_fix : quot_fix;
    end else begin
      calc_res = op_sel_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          state_d = ST_PREP;
          op_d    = op;
          a_d     = src1;
          b_d     = src2;
        end
      end
      ST_PREP: begin
        acc_d     = {{XLEN{1'b0}}, mag1};
        opnd_d    = mag2;
        cnt_d     = '0;
        // remainder follows the dividend; for MULHSU s2 is always 0 so
        // s1^s2 reduces to s1
        neg_d     = op_is_rem(op_q) ? s1 : (s1 ^ s2);
        special_d = special;
`ifdef YSYX_24100027_MDU_FAST_PATH_EN
        if (special) begin
          result_d = special_res;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_CALC;
        end
`else
        state_d   = ST_CALC;
`endif
      end
      ST_CALC: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = special_q ? special_res : calc_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a cancelled op never touches the visible result
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign dbg_state_o = state_q;

endmodule
